// File: rtl/decode_wb_stage.sv
// decode_wb_stage: Y86-64 decode/writeback stage with regfile, operand forwarding and D->E register.
// Optional DECODE_HAZARD_CNT_EN adds a saturating load-use bubble counter (hz_count, hz_clr).
module decode_wb_stage #(
   parameter int DATA_W = 64,
   parameter int REG_W  = 4,
   parameter int NREGS  = 15,
   parameter int RNONE  = 15,
   parameter int RSP    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        D_stat,
   input  logic [3:0]        D_icode,
   input  logic [3:0]        D_ifun,
   input  logic [REG_W-1:0]  D_rA,
   input  logic [REG_W-1:0]  D_rB,
   input  logic [DATA_W-1:0] D_valC,
   input  logic [DATA_W-1:0] D_valP,
   input  logic [3:0]        E_icode_in,
   input  logic [REG_W-1:0]  E_dstM_in,
   input  logic [REG_W-1:0]  e_dstE,
   input  logic [DATA_W-1:0] e_valE,
   input  logic [REG_W-1:0]  M_dstE,
   input  logic [DATA_W-1:0] M_valE,
   input  logic [REG_W-1:0]  M_dstM,
   input  logic [DATA_W-1:0] m_valM,
   input  logic [REG_W-1:0]  W_dstE,
   input  logic [DATA_W-1:0] W_valE,
   input  logic [REG_W-1:0]  W_dstM,
   input  logic [DATA_W-1:0] W_valM,
   input  logic              E_stall,
   input  logic              E_bubble,
`ifdef DECODE_HAZARD_CNT_EN
   input  logic              hz_clr,
   output logic [31:0]       hz_count,
`endif
   output logic [REG_W-1:0]  d_srcA,
   output logic [REG_W-1:0]  d_srcB,
   output logic              load_use,
   output logic [3:0]        E_stat,
   output logic [3:0]        E_icode,
   output logic [3:0]        E_ifun,
   output logic [DATA_W-1:0] E_valC,
   output logic [DATA_W-1:0] E_valA,
   output logic [DATA_W-1:0] E_valB,
   output logic [REG_W-1:0]  E_dstE,
   output logic [REG_W-1:0]  E_dstM,
   output logic [REG_W-1:0]  E_srcA,
   output logic [REG_W-1:0]  E_srcB
);

   localparam logic [REG_W-1:0] RN = REG_W'(RNONE);
   localparam logic [REG_W-1:0] SP = REG_W'(RSP);

   typedef struct packed {
      logic [3:0]        stat;
      logic [3:0]        icode;
      logic [3:0]        ifun;
      logic [DATA_W-1:0] valC;
      logic [DATA_W-1:0] valA;
      logic [DATA_W-1:0] valB;
      logic [REG_W-1:0]  dstE;
      logic [REG_W-1:0]  dstM;
      logic [REG_W-1:0]  srcA;
      logic [REG_W-1:0]  srcB;
   } bundle_t;

   localparam bundle_t BUBBLE = '{stat: 4'd1, icode: 4'd1, ifun: 4'd0,
                                  valC: '0, valA: '0, valB: '0,
                                  dstE: RN, dstM: RN, srcA: RN, srcB: RN};

   logic [DATA_W-1:0] rf_q [NREGS];
   logic [DATA_W-1:0] rf_d [NREGS];
   bundle_t           e_q, e_d, dec;
   logic [REG_W-1:0]  d_dstE, d_dstM;

   function automatic logic [DATA_W-1:0] rf_rd(input logic [REG_W-1:0] s);
      rf_rd = (s != RN && int'(s) < NREGS) ? rf_q[s] : '0;
   endfunction

   // Youngest producer first: e beats M (load before ALU) beats W (load before ALU).
   function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0] s);
      fwd = (s == RN)     ? '0     :
            (s == e_dstE) ? e_valE :
            (s == M_dstM) ? m_valM :
            (s == M_dstE) ? M_valE :
            (s == W_dstM) ? W_valM :
            (s == W_dstE) ? W_valE : rf_rd(s);
   endfunction

   always_comb begin
      d_srcA = (D_icode inside {4'd2, 4'd4, 4'd6, 4'd10}) ? D_rA :
               (D_icode inside {4'd9, 4'd11}) ? SP : RN;
      d_srcB = (D_icode inside {4'd4, 4'd5, 4'd6}) ? D_rB :
               (D_icode inside {4'd8, 4'd9, 4'd10, 4'd11}) ? SP : RN;
      d_dstE = (D_icode inside {4'd2, 4'd3, 4'd6}) ? D_rB :
               (D_icode inside {4'd8, 4'd9, 4'd10, 4'd11}) ? SP : RN;
      d_dstM = (D_icode inside {4'd5, 4'd11}) ? D_rA : RN;
      load_use = (E_icode_in == 4'd5 || E_icode_in == 4'd11) && E_dstM_in != RN &&
                 (E_dstM_in == d_srcA || E_dstM_in == d_srcB);
      dec.stat  = D_stat;
      dec.icode = D_icode;
      dec.ifun  = D_ifun;
      dec.valC  = D_valC;
      dec.valA  = (D_icode == 4'd7 || D_icode == 4'd8) ? D_valP : fwd(d_srcA);
      dec.valB  = fwd(d_srcB);
      dec.dstE  = d_dstE;
      dec.dstM  = d_dstM;
      dec.srcA  = d_srcA;
      dec.srcB  = d_srcB;
      e_d = E_bubble ? BUBBLE : E_stall ? e_q : dec;
   end

   // valM port is listed first so it wins when both W destinations collide.
   always_comb begin
      for (int i = 0; i < NREGS; i++)
         rf_d[i] = (W_dstM == REG_W'(i) && W_dstM != RN) ? W_valM :
                   (W_dstE == REG_W'(i) && W_dstE != RN) ? W_valE : rf_q[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q <= BUBBLE;
         for (int i = 0; i < NREGS; i++)
            rf_q[i] <= '0;
      end else begin
         e_q <= e_d;
         rf_q <= rf_d;
      end
   end

   assign E_stat  = e_q.stat;
   assign E_icode = e_q.icode;
   assign E_ifun  = e_q.ifun;
   assign E_valC  = e_q.valC;
   assign E_valA  = e_q.valA;
   assign E_valB  = e_q.valB;
   assign E_dstE  = e_q.dstE;
   assign E_dstM  = e_q.dstM;
   assign E_srcA  = e_q.srcA;
   assign E_srcB  = e_q.srcB;

`ifdef DECODE_HAZARD_CNT_EN
   logic [31:0] hz_q, hz_d;

   always_comb begin
      hz_d = hz_clr ? 32'd0 :
             (load_use && E_bubble && hz_q != 32'hFFFF_FFFF) ? hz_q + 32'd1 : hz_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hz_q <= 32'd0;
      else        hz_q <= hz_d;
   end

   assign hz_count = hz_q;
`endif

endmodule

// File: tb/tb_decode_wb_stage.sv
// tb_decode_wb_stage: directed-vector bench for decode_wb_stage (regfile, forwarding, hazards, D->E control).
// Build with DECODE_HAZARD_CNT_EN defined to also exercise the hazard counter.
module tb_decode_wb_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  D_stat, D_icode, D_ifun, E_icode_in;
   logic [3:0]  D_rA, D_rB, E_dstM_in, e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [63:0] D_valC, D_valP, e_valE, M_valE, m_valM, W_valE, W_valM;
   logic        E_stall, E_bubble;
   logic [3:0]  d_srcA, d_srcB;
   logic        load_use;
   logic [3:0]  E_stat, E_icode, E_ifun;
   logic [63:0] E_valC, E_valA, E_valB;
   logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
`ifdef DECODE_HAZARD_CNT_EN
   logic        hz_clr;
   logic [31:0] hz_count;
`endif
   int vec = 0;
   int err = 0;

   decode_wb_stage dut (
      .clk(clk), .rst_n(rst_n),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP), .E_icode_in(E_icode_in), .E_dstM_in(E_dstM_in),
      .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
      .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
      .W_dstM(W_dstM), .W_valM(W_valM), .E_stall(E_stall), .E_bubble(E_bubble),
`ifdef DECODE_HAZARD_CNT_EN
      .hz_clr(hz_clr), .hz_count(hz_count),
`endif
      .d_srcA(d_srcA), .d_srcB(d_srcB), .load_use(load_use),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
      .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      D_stat = 4'd1; D_icode = 4'd1; D_ifun = 4'd0; D_rA = 4'hF; D_rB = 4'hF;
      D_valC = '0; D_valP = '0; E_icode_in = 4'd1; E_dstM_in = 4'hF;
      e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
      e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
      E_stall = 1'b0; E_bubble = 1'b0;
`ifdef DECODE_HAZARD_CNT_EN
      hz_clr = 1'b0;
`endif
   endtask

   task automatic opq(input logic [3:0] a, input logic [3:0] b);
      D_icode = 4'd6; D_ifun = 4'd0; D_rA = a; D_rB = b;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      step();
      step();
      vec++; if (E_icode !== 4'd1) begin err++; $display("FAIL reset_icode got %0h exp 1", E_icode); end
      vec++; if (E_stat !== 4'd1) begin err++; $display("FAIL reset_stat got %0h exp 1", E_stat); end
      vec++; if (E_dstE !== 4'hF) begin err++; $display("FAIL reset_dstE got %0h exp f", E_dstE); end
      vec++; if (E_valA !== 64'd0) begin err++; $display("FAIL reset_valA got %0h exp 0", E_valA); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_writeback();
      idle();
      W_dstE = 4'd3; W_valE = 64'd5;
      step();
      idle();
      opq(4'd3, 4'd3);
      #1;
      vec++; if (d_srcA !== 4'd3) begin err++; $display("FAIL wb_srcA got %0h exp 3", d_srcA); end
      vec++; if (d_srcB !== 4'd3) begin err++; $display("FAIL wb_srcB got %0h exp 3", d_srcB); end
      step();
      vec++; if (E_valA !== 64'd5) begin err++; $display("FAIL wb_valA got %0h exp 5", E_valA); end
      vec++; if (E_valB !== 64'd5) begin err++; $display("FAIL wb_valB got %0h exp 5", E_valB); end
      vec++; if (E_dstE !== 4'd3) begin err++; $display("FAIL wb_dstE got %0h exp 3", E_dstE); end
      vec++; if (E_icode !== 4'd6) begin err++; $display("FAIL wb_icode got %0h exp 6", E_icode); end
   endtask

   task automatic test_forward();
      idle();
      opq(4'd2, 4'd2);
      e_dstE = 4'd2; e_valE = 64'hA;
      M_dstE = 4'd2; M_valE = 64'hB;
      W_dstE = 4'd2; W_valE = 64'hC;
      step();
      vec++; if (E_valA !== 64'hA) begin err++; $display("FAIL fwd_e_valA got %0h exp a", E_valA); end
      vec++; if (E_valB !== 64'hA) begin err++; $display("FAIL fwd_e_valB got %0h exp a", E_valB); end
      e_dstE = 4'hF;
      step();
      vec++; if (E_valA !== 64'hB) begin err++; $display("FAIL fwd_ME_valA got %0h exp b", E_valA); end
      M_dstM = 4'd2; m_valM = 64'hD;
      step();
      vec++; if (E_valA !== 64'hD) begin err++; $display("FAIL fwd_MM_valA got %0h exp d", E_valA); end
      M_dstM = 4'hF; M_dstE = 4'hF;
      W_valE = 64'hE;
      step();
      vec++; if (E_valA !== 64'hE) begin err++; $display("FAIL fwd_W_valA got %0h exp e", E_valA); end
      W_dstE = 4'hF;
      step();
      vec++; if (E_valA !== 64'hE) begin err++; $display("FAIL fwd_rf_valA got %0h exp e", E_valA); end
   endtask

   task automatic test_same_reg();
      idle();
      W_dstE = 4'd6; W_dstM = 4'd6; W_valE = 64'd1; W_valM = 64'd2;
      step();
      idle();
      opq(4'd6, 4'd6);
      step();
      vec++; if (E_valA !== 64'd2) begin err++; $display("FAIL samereg_valA got %0h exp 2", E_valA); end
   endtask

   task automatic test_load_use();
      idle();
      opq(4'd1, 4'd3);
      E_icode_in = 4'd5; E_dstM_in = 4'd1;
      #1;
      vec++; if (load_use !== 1'b1) begin err++; $display("FAIL lu_mrmov got %0b exp 1", load_use); end
      E_icode_in = 4'd6;
      #1;
      vec++; if (load_use !== 1'b0) begin err++; $display("FAIL lu_opq got %0b exp 0", load_use); end
      E_icode_in = 4'd11; E_dstM_in = 4'hF; D_rA = 4'hF;
      #1;
      vec++; if (load_use !== 1'b0) begin err++; $display("FAIL lu_rnone got %0b exp 0", load_use); end
      E_icode_in = 4'd5; E_dstM_in = 4'd1; D_rA = 4'd1;
      E_bubble = 1'b1;
      step();
      vec++; if (E_icode !== 4'd1) begin err++; $display("FAIL lu_bub_icode got %0h exp 1", E_icode); end
      vec++; if (E_dstE !== 4'hF) begin err++; $display("FAIL lu_bub_dstE got %0h exp f", E_dstE); end
      vec++; if (E_valA !== 64'd0) begin err++; $display("FAIL lu_bub_valA got %0h exp 0", E_valA); end
   endtask

   task automatic test_stall_bubble();
      idle();
      opq(4'd3, 4'd3);
      step();
      vec++; if (E_icode !== 4'd6) begin err++; $display("FAIL sb_load got %0h exp 6", E_icode); end
      E_bubble = 1'b1; E_stall = 1'b1;
      step();
      vec++; if (E_icode !== 4'd1) begin err++; $display("FAIL sb_bubble_wins got %0h exp 1", E_icode); end
      E_bubble = 1'b0; E_stall = 1'b0;
      opq(4'd3, 4'd6);
      step();
      E_stall = 1'b1;
      D_icode = 4'd8; D_valP = 64'h77;
      for (int k = 0; k < 3; k++) begin
         step();
         vec++; if (E_icode !== 4'd6) begin err++; $display("FAIL stall_icode[%0d] got %0h exp 6", k, E_icode); end
         vec++; if (E_valA !== 64'd5) begin err++; $display("FAIL stall_valA[%0d] got %0h exp 5", k, E_valA); end
         vec++; if (E_valB !== 64'd2) begin err++; $display("FAIL stall_valB[%0d] got %0h exp 2", k, E_valB); end
         vec++; if (E_dstE !== 4'd6) begin err++; $display("FAIL stall_dstE[%0d] got %0h exp 6", k, E_dstE); end
      end
      #2 rst_n = 1'b0;
      #1;
      vec++; if (E_icode !== 4'd1) begin err++; $display("FAIL rst_stall_icode got %0h exp 1", E_icode); end
      vec++; if (E_valB !== 64'd0) begin err++; $display("FAIL rst_stall_valB got %0h exp 0", E_valB); end
      vec++; if (E_dstE !== 4'hF) begin err++; $display("FAIL rst_stall_dstE got %0h exp f", E_dstE); end
      rst_n = 1'b1;
      idle();
      opq(4'd3, 4'd6);
      step();
      vec++; if (E_valA !== 64'd0) begin err++; $display("FAIL rst_rf_clear got %0h exp 0", E_valA); end
      vec++; if (E_icode !== 4'd6) begin err++; $display("FAIL rst_resume got %0h exp 6", E_icode); end
   endtask

   task automatic test_call();
      idle();
      D_icode = 4'd8; D_valP = 64'h40; D_valC = 64'h99;
      M_dstE = 4'd4; M_valE = 64'h100;
      step();
      vec++; if (E_valA !== 64'h40) begin err++; $display("FAIL call_valA got %0h exp 40", E_valA); end
      vec++; if (E_srcB !== 4'd4) begin err++; $display("FAIL call_srcB got %0h exp 4", E_srcB); end
      vec++; if (E_dstE !== 4'd4) begin err++; $display("FAIL call_dstE got %0h exp 4", E_dstE); end
      vec++; if (E_srcA !== 4'hF) begin err++; $display("FAIL call_srcA got %0h exp f", E_srcA); end
      vec++; if (E_valC !== 64'h99) begin err++; $display("FAIL call_valC got %0h exp 99", E_valC); end
      vec++; if (E_valB !== 64'h100) begin err++; $display("FAIL call_valB got %0h exp 100", E_valB); end
   endtask

   task automatic test_popq();
      idle();
      D_icode = 4'd11; D_rA = 4'd5;
      #1;
      vec++; if (d_srcA !== 4'd4) begin err++; $display("FAIL popq_srcA got %0h exp 4", d_srcA); end
      step();
      vec++; if (E_dstM !== 4'd5) begin err++; $display("FAIL popq_dstM got %0h exp 5", E_dstM); end
      vec++; if (E_dstE !== 4'd4) begin err++; $display("FAIL popq_dstE got %0h exp 4", E_dstE); end
   endtask

`ifdef DECODE_HAZARD_CNT_EN
   task automatic test_hz_count();
      idle();
      hz_clr = 1'b1;
      step();
      hz_clr = 1'b0;
      opq(4'd1, 4'd3);
      E_icode_in = 4'd5; E_dstM_in = 4'd1; E_bubble = 1'b1;
      repeat (3) step();
      vec++; if (hz_count !== 32'd3) begin err++; $display("FAIL hz_three got %0d exp 3", hz_count); end
      hz_clr = 1'b1;
      step();
      vec++; if (hz_count !== 32'd0) begin err++; $display("FAIL hz_clr got %0d exp 0", hz_count); end
      hz_clr = 1'b0; E_bubble = 1'b0;
      step();
      vec++; if (hz_count !== 32'd0) begin err++; $display("FAIL hz_nobub got %0d exp 0", hz_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_writeback();
      test_forward();
      test_same_reg();
      test_load_use();
      test_stall_bubble();
      test_call();
      test_popq();
`ifdef DECODE_HAZARD_CNT_EN
      test_hz_count();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
